// File: rtl/ordering_port_if.sv
`default_nettype none
// ============================================================================
// Module      : ordering_port_if
// Description : Bundles the packed-beat host side and the per-city memory
//               side of the ordering port. The port itself is the slave;
//               the host/memory environment is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface ordering_port_if #(
  parameter int CITY_LOG = 5
);
  logic                ordering_write;
  logic [63:0]         ordering_wdata;
  logic                ordering_read;
  logic [63:0]         ordering_rdata;
  logic                ordering_ready;
  logic                ptr_clear;
  logic                mem_we;
  logic                mem_re;
  logic [CITY_LOG-1:0] mem_addr;
  logic [7:0]          mem_wdata;
  logic [7:0]          mem_rdata;
  logic                overflow;

  modport slave (
    input  ordering_write, ordering_wdata, ordering_read, ptr_clear, mem_rdata,
    output ordering_rdata, ordering_ready, mem_we, mem_re, mem_addr, mem_wdata,
           overflow
  );

  modport master (
    output ordering_write, ordering_wdata, ordering_read, ptr_clear, mem_rdata,
    input  ordering_rdata, ordering_ready, mem_we, mem_re, mem_addr, mem_wdata,
           overflow
  );
endinterface
`default_nettype wire

// File: rtl/ordering_port.sv
`default_nettype none
// ============================================================================
// Module      : ordering_port
// Description : Unpacks 64-bit ordering beats (8 cities x 8 bit) into eight
//               sequential memory writes, and gathers eight sequential memory
//               reads into a held 64-bit beat. One pending request slot.
// Revision    : 1.0 - initial release
// ============================================================================
module ordering_port #(
  parameter int CITY_NUM = 32,
  parameter int CITY_LOG = 5
) (
  input  logic           clk,
  input  logic           reset,
  ordering_port_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_TAIL = 2'd3
  } state_t;

  localparam logic [CITY_LOG:0] C_CITY_NUM = (CITY_LOG+1)'(CITY_NUM);
  localparam logic [CITY_LOG:0] C_BEAT     = (CITY_LOG+1)'(8);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [CITY_LOG-1:0] r_wr_ptr, r_rd_ptr;
  logic [63:0]         r_wbeat, r_rdata, r_pend_data;
  logic                r_pend_valid, r_pend_rd, r_clr_pend, r_ready, r_overflow;

  logic                w_busy, w_last, w_can_start;
  logic                w_start, w_start_rd;
  logic [63:0]         w_start_data, w_pend_data_nxt;
  logic                w_pend_valid_nxt, w_pend_rd_nxt, w_drop;
  logic [2:0]          w_cap_idx;

  // Pointers advance one beat and wrap to 0 on reaching CITY_NUM.
  function automatic logic [CITY_LOG-1:0] bump(input logic [CITY_LOG-1:0] p);
    logic [CITY_LOG:0] s;
    s = {1'b0, p} + C_BEAT;
    return (s >= C_CITY_NUM) ? '0 : s[CITY_LOG-1:0];
  endfunction

  assign w_busy      = (r_state != IDLE);
  // Last cycle of an operation: a queued or fresh request may start next.
  assign w_last      = ((r_state == WR) && (r_idx == 3'd7)) || (r_state == RD_TAIL);
  assign w_can_start = !w_busy || w_last;
  // Read data lags the strobe by one cycle, so capture trails idx by one.
  assign w_cap_idx   = (r_state == RD_TAIL) ? 3'd7 : (r_idx - 3'd1);

  assign bus.mem_we         = (r_state == WR);
  assign bus.mem_re         = (r_state == RD);
  assign bus.mem_addr       = (r_state == WR) ? (r_wr_ptr + CITY_LOG'(r_idx)) :
                              (r_state == RD) ? (r_rd_ptr + CITY_LOG'(r_idx)) : '0;
  assign bus.mem_wdata      = (r_state == WR) ? r_wbeat[{r_idx, 3'b000} +: 8] : 8'd0;
  assign bus.ordering_rdata = r_rdata;
  assign bus.ordering_ready = r_ready;
  assign bus.overflow       = r_overflow;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state, start selection and pending-slot bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_start          = 1'b0;
    w_start_rd       = 1'b0;
    w_start_data     = bus.ordering_wdata;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_rd_nxt    = r_pend_rd;
    w_pend_data_nxt  = r_pend_data;
    w_drop           = 1'b0;

    // Pending request has priority, then write, then read.
    if (r_pend_valid) begin
      w_start      = 1'b1;
      w_start_rd   = r_pend_rd;
      w_start_data = r_pend_data;
    end else if (bus.ordering_write) begin
      w_start = 1'b1;
    end else if (bus.ordering_read) begin
      w_start    = 1'b1;
      w_start_rd = 1'b1;
    end

    // Slot is refilled by the first request not started; any further is lost.
    if (w_can_start && !r_pend_valid) begin
      w_pend_valid_nxt = bus.ordering_write && bus.ordering_read;
      w_pend_rd_nxt    = 1'b1;
    end else if (w_can_start || !r_pend_valid) begin
      w_pend_valid_nxt = bus.ordering_write || bus.ordering_read;
      w_pend_rd_nxt    = !bus.ordering_write;
      w_pend_data_nxt  = bus.ordering_wdata;
      w_drop           = bus.ordering_write && bus.ordering_read;
    end else begin
      w_drop = bus.ordering_write || bus.ordering_read;
    end

    if (w_can_start) begin
      w_idx_nxt   = 3'd0;
      w_state_nxt = !w_start ? IDLE : (w_start_rd ? RD : WR);
    end else begin
      w_idx_nxt = r_idx + 3'd1;
      if ((r_state == RD) && (r_idx == 3'd7)) begin
        w_state_nxt = RD_TAIL;
      end
    end
  end

  // Datapath: beat latches, capture, pointers, flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_wbeat      <= '0;
      r_rdata      <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_rd    <= 1'b0;
      r_clr_pend   <= 1'b0;
      r_ready      <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_rd    <= w_pend_rd_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_ready      <= (w_state_nxt == IDLE);

      if (w_can_start && w_start && !w_start_rd) begin
        r_wbeat <= w_start_data;
      end

      if (((r_state == RD) && (r_idx != 3'd0)) || (r_state == RD_TAIL)) begin
        r_rdata[{w_cap_idx, 3'b000} +: 8] <= bus.mem_rdata;
      end

      // A clear during an operation is deferred so its addresses stay intact.
      if (w_last) begin
        r_clr_pend <= 1'b0;
        if (bus.ptr_clear || r_clr_pend) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else if (r_state == WR) begin
          r_wr_ptr <= bump(r_wr_ptr);
        end else begin
          r_rd_ptr <= bump(r_rd_ptr);
        end
      end else if (!w_busy) begin
        if (bus.ptr_clear) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end
      end else if (bus.ptr_clear) begin
        r_clr_pend <= 1'b1;
      end

      // A lost request outranks a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.ptr_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ordering_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_ordering_port
// Description : Bench for ordering_port: directed scenarios with literal
//               expectations plus randomized traffic against a transaction
//               level model of the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ordering_port;
  localparam int CITY_NUM = 32;
  localparam int CITY_LOG = 5;

  typedef struct packed {
    logic        is_rd;
    logic [63:0] data;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  ordering_port_if #(.CITY_LOG(CITY_LOG)) bus_if ();

  ordering_port #(.CITY_NUM(CITY_NUM), .CITY_LOG(CITY_LOG)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Environment memory (synchronous read) and the bench's expected image of it.
  logic [7:0] env_mem[CITY_NUM];
  logic [7:0] shadow[CITY_NUM];

  // Memory responder: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus_if.mem_we) env_mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    if (bus_if.mem_re) bus_if.mem_rdata <= env_mem[bus_if.mem_addr];
  end

  // ---------------- transaction-level model ----------------
  int          m_kind;   // 0 none, 1 write, 2 read
  int          m_cyc;    // cycle number within operation (1-based)
  int          m_base;
  logic [63:0] m_data;
  int          m_wr, m_rd;
  bit          m_clr, m_ovf, m_ready;
  logic [63:0] m_rdata;
  req_t        pend[$];

  // Advance the model one clock using the requests seen at this edge.
  always @(posedge clk or posedge reset) begin : model_step
    req_t lst[$];
    req_t r;
    int   drops;
    bit   busy, last, pc;
    if (reset) begin
      m_kind = 0; m_cyc = 0; m_base = 0; m_data = '0;
      m_wr = 0; m_rd = 0; m_clr = 0; m_ovf = 0; m_ready = 1; m_rdata = '0;
      pend.delete();
    end else begin
      pc   = bus_if.ptr_clear;
      busy = (m_kind != 0);
      last = busy && (m_cyc == ((m_kind == 1) ? 8 : 9));
      if (m_kind == 1) shadow[m_base + m_cyc - 1] = m_data[8*(m_cyc-1) +: 8];
      if (m_kind == 2 && m_cyc >= 2) m_rdata[8*(m_cyc-2) +: 8] = shadow[m_base + m_cyc - 2];
      lst = pend;
      pend.delete();
      if (bus_if.ordering_write) begin r.is_rd = 1'b0; r.data = bus_if.ordering_wdata; lst.push_back(r); end
      if (bus_if.ordering_read)  begin r.is_rd = 1'b1; r.data = '0; lst.push_back(r); end
      if (busy && !last) begin
        m_cyc++;
        if (pc) m_clr = 1;
        if (lst.size() > 0) pend.push_back(lst.pop_front());
        drops = lst.size();
      end else begin
        if (last) begin
          if (pc || m_clr) begin m_wr = 0; m_rd = 0; end
          else if (m_kind == 1) m_wr = (m_wr + 8) % CITY_NUM;
          else m_rd = (m_rd + 8) % CITY_NUM;
          m_clr = 0;
        end else if (pc) begin
          m_wr = 0; m_rd = 0;
        end
        m_kind = 0;
        if (lst.size() > 0) begin
          r = lst.pop_front();
          m_kind = r.is_rd ? 2 : 1;
          m_cyc  = 1;
          m_data = r.data;
          m_base = r.is_rd ? m_rd : m_wr;
        end
        if (lst.size() > 0) pend.push_back(lst.pop_front());
        drops = lst.size();
      end
      if (drops > 0) m_ovf = 1;
      else if (pc) m_ovf = 0;
      m_ready = (m_kind == 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model in mid-cycle.
  always @(negedge clk) begin : compare
    logic        ewe, ere;
    logic [63:0] eaddr, ewd;
    if (!reset) begin
      ewe   = (m_kind == 1);
      ere   = (m_kind == 2) && (m_cyc <= 8);
      eaddr = (ewe || ere) ? 64'(m_base + m_cyc - 1) : 64'd0;
      ewd   = ewe ? 64'(m_data[8*(m_cyc-1) +: 8]) : 64'd0;
      chk("mem_we", 64'(bus_if.mem_we), 64'(ewe));
      chk("mem_re", 64'(bus_if.mem_re), 64'(ere));
      chk("mem_addr", 64'(bus_if.mem_addr), eaddr);
      chk("mem_wdata", 64'(bus_if.mem_wdata), ewd);
      chk("ready", 64'(bus_if.ordering_ready), 64'(m_ready));
      chk("overflow", 64'(bus_if.overflow), 64'(m_ovf));
      chk("rdata", bus_if.ordering_rdata, m_rdata);
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus_if.ordering_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL %s: ready got 0 expected 1 within 40 cycles", tag);
    end
  endtask

  task automatic pulse_read();
    bus_if.ordering_read = 1'b1;
    @(negedge clk);
    bus_if.ordering_read = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_if.ptr_clear = 1'b1;
    @(negedge clk);
    bus_if.ptr_clear = 1'b0;
  endtask

  int starts[5] = '{0, 8, 16, 24, 0};

  initial begin
    logic [7:0]  v;
    logic [63:0] beat;
    bus_if.ordering_write = 1'b0;
    bus_if.ordering_read  = 1'b0;
    bus_if.ordering_wdata = '0;
    bus_if.ptr_clear      = 1'b0;
    bus_if.mem_rdata      = '0;
    for (int i = 0; i < CITY_NUM; i++) begin
      v = 8'($urandom);
      env_mem[i] = v;
      shadow[i]  = v;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", 64'(bus_if.ordering_ready), 64'd1);
    chk("reset_rdata", bus_if.ordering_rdata, 64'd0);
    chk("reset_ovf", 64'(bus_if.overflow), 64'd0);

    // Write then read back one beat.
    bus_if.ordering_write = 1'b1;
    bus_if.ordering_wdata = 64'h0706050403020100;
    @(negedge clk);
    bus_if.ordering_write = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("t1_we", 64'(bus_if.mem_we), 64'd1);
      chk("t1_waddr", 64'(bus_if.mem_addr), 64'(k - 1));
      chk("t1_wdata", 64'(bus_if.mem_wdata), 64'(k - 1));
      @(negedge clk);
    end
    chk("t1_wr_ready9", 64'(bus_if.ordering_ready), 64'd1);
    pulse_read();
    chk("t1_rd_ready1", 64'(bus_if.ordering_ready), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      chk("t1_re", 64'(bus_if.mem_re), 64'd1);
      chk("t1_raddr", 64'(bus_if.mem_addr), 64'(k - 1));
      @(negedge clk);
    end
    chk("t1_rd_ready9", 64'(bus_if.ordering_ready), 64'd0);
    @(negedge clk);
    chk("t1_rd_ready10", 64'(bus_if.ordering_ready), 64'd1);
    chk("t1_rdata", bus_if.ordering_rdata, 64'h0706050403020100);

    // Five reads walk the read pointer round the table.
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      pulse_read();
      chk("t2_start", 64'(bus_if.mem_addr), 64'(starts[i]));
      wait_ready("t2_wait");
    end

    // Read arriving during write cycle 3 is queued behind it.
    pulse_clear();
    beat = {$urandom, $urandom};
    bus_if.ordering_write = 1'b1;
    bus_if.ordering_wdata = beat;
    @(negedge clk);
    bus_if.ordering_write = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bus_if.ordering_read = (c == 3);
      chk("t3_ready", 64'(bus_if.ordering_ready), 64'd0);
      if (c == 8) chk("t3_last_we", 64'(bus_if.mem_we), 64'd1);
      if (c == 9) chk("t3_first_re", 64'(bus_if.mem_re), 64'd1);
      if (c == 9) chk("t3_raddr", 64'(bus_if.mem_addr), 64'd0);
      @(negedge clk);
    end
    chk("t3_ready18", 64'(bus_if.ordering_ready), 64'd1);
    chk("t3_rdata", bus_if.ordering_rdata, beat);

    // Write, write, read back to back: the read is lost.
    bus_if.ordering_write = 1'b1;
    bus_if.ordering_wdata = {$urandom, $urandom};
    @(negedge clk);
    bus_if.ordering_wdata = {$urandom, $urandom};
    @(negedge clk);
    bus_if.ordering_write = 1'b0;
    bus_if.ordering_read  = 1'b1;
    @(negedge clk);
    bus_if.ordering_read = 1'b0;
    chk("t4_ovf_set", 64'(bus_if.overflow), 64'd1);
    wait_ready("t4_wait");
    chk("t4_ovf_sticky", 64'(bus_if.overflow), 64'd1);
    pulse_clear();
    chk("t4_ovf_clr", 64'(bus_if.overflow), 64'd0);

    // Clear during a read at idx 4: read finishes, next starts at 0.
    pulse_read();
    for (int k = 1; k <= 8; k++) begin
      bus_if.ptr_clear = (k == 5);
      chk("t5_raddr", 64'(bus_if.mem_addr), 64'(k - 1));
      @(negedge clk);
    end
    bus_if.ptr_clear = 1'b0;
    wait_ready("t5_wait");
    pulse_read();
    chk("t5_next_start", 64'(bus_if.mem_addr), 64'd0);
    wait_ready("t5_wait2");

    // Reset in write cycle 5.
    bus_if.ordering_write = 1'b1;
    bus_if.ordering_wdata = {$urandom, $urandom};
    @(negedge clk);
    bus_if.ordering_write = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_we_before", 64'(bus_if.mem_we), 64'd1);
    #1 reset = 1'b1;
    #1 chk("t6_we_async", 64'(bus_if.mem_we), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("t6_ready", 64'(bus_if.ordering_ready), 64'd1);
    chk("t6_ovf", 64'(bus_if.overflow), 64'd0);
    chk("t6_rdata", bus_if.ordering_rdata, 64'd0);
    bus_if.ordering_write = 1'b1;
    @(negedge clk);
    bus_if.ordering_write = 1'b0;
    chk("t6_wr_start", 64'(bus_if.mem_addr), 64'd0);
    wait_ready("t6_wait");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus_if.ordering_write = ($urandom_range(0, 5) == 0);
      bus_if.ordering_read  = ($urandom_range(0, 5) == 0);
      bus_if.ordering_wdata = {$urandom, $urandom};
      bus_if.ptr_clear      = ($urandom_range(0, 29) == 0);
      reset                 = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    bus_if.ordering_write = 1'b0;
    bus_if.ordering_read  = 1'b0;
    bus_if.ptr_clear      = 1'b0;
    reset                 = 1'b0;
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
